axis_video_pattern_gen: RTL

- AXI4-Stream video master that drives the MM2S input of the filter pipeline in place of the VDMA.
- Emits full frames of 32-bit {8'h00,R,G,B} pixels, with TUSER marking start-of-frame and TLAST marking end-of-line.
- Used for board bring-up and as the stimulus source in filter regression; honours TREADY backpressure.

---
 rtl/axis_video_pattern_gen.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video test-pattern master.
// Emits full frames of {8'h00,R,G,B} pixels. TUSER marks start-of-frame and
// TLAST marks end-of-line. The block honours TREADY backpressure.
//
// Handshake: a beat transfers on a rising clock edge where TVALID && TREADY.
// Once TVALID is high it stays high until the frame's last beat has been
// accepted. While TVALID is high and TREADY is low, TDATA, TKEEP, TLAST and
// TUSER hold their values.
module axis_video_pattern_gen #(
  parameter int IMG_H = 1080,
  parameter int IMG_W = 1920,
  parameter int TBITS = 32,
  parameter int TBYTE = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic [1:0]       pattern_sel,
  input  logic [23:0]      solid_rgb,
  output logic             M_AXIS_TVALID,
  input  logic             M_AXIS_TREADY,
  output logic [TBITS-1:0] M_AXIS_TDATA,
  output logic [TBYTE-1:0] M_AXIS_TKEEP,
  output logic             M_AXIS_TLAST,
  output logic             M_AXIS_TUSER,
  output logic             busy,
  output logic             frame_done,
  output logic [1:0]       dbg_state
);

  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int BAR_W = IMG_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FEND   = 2'd2
  } state_t;

  state_t state;

  // Coordinates and generator state of the beat currently on the bus.
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [2:0]    bar;
  logic [XW-1:0] run;
  logic [31:0]   idx;
  logic [1:0]    pat;
  logic [23:0]   solid;

  // Precomputed values for the pixel after the current one.
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [2:0]    nbar;
  logic [XW-1:0] nrun;
  logic [31:0]   nidx;
  logic [7:0]    nx_r;
  logic          last_x;
  logic          last_y;

  function automatic logic [23:0] bar_col(input logic [2:0] b);
    logic [23:0] c;
    case (b)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] pix(input logic [1:0]  p,
                                      input logic [23:0] s,
                                      input logic [7:0]  r,
                                      input logic [2:0]  b,
                                      input logic [31:0] i);
    logic [31:0] d;
    case (p)
      2'd0:    d = {8'h00, s};
      2'd1:    d = {8'h00, r, r, r};
      2'd2:    d = {8'h00, bar_col(b)};
      default: d = i;
    endcase
    return d;
  endfunction

  // The ramp uses x modulo 256. Narrow lines are zero-extended to 8 bits.
  if (XW >= 8) begin : g_ramp_wide
    assign nx_r = nx[7:0];
  end else begin : g_ramp_narrow
    assign nx_r = {{(8 - XW){1'b0}}, nx};
  end

  // Next-pixel coordinates. The bar index is a run counter, not a divider.
  // The bar index saturates at 7 so that the last bar absorbs the remainder.
  always_comb begin
    last_x = (x == XW'(IMG_W - 1));
    last_y = (y == YW'(IMG_H - 1));
    nx     = last_x ? '0 : x + XW'(1);
    ny     = last_x ? y + YW'(1) : y;
    nbar   = bar;
    nrun   = run;
    nidx   = idx + 32'd1;
    if (last_x) begin
      nbar = 3'd0;
      nrun = '0;
    end else if (bar != 3'd7) begin
      if (run == XW'(BAR_W - 1)) begin
        nbar = bar + 3'd1;
        nrun = '0;
      end else begin
        nrun = run + XW'(1);
      end
    end
  end

  // Frame FSM. All stream outputs are registered here.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      bar           <= '0;
      run           <= '0;
      idx           <= '0;
      pat           <= '0;
      solid         <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TKEEP  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TUSER  <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      case (state)
        IDLE, FEND: begin
          frame_done <= 1'b0;
          if (enable) begin
            // A new frame re-latches the settings and presents pixel (0,0).
            pat           <= pattern_sel;
            solid         <= solid_rgb;
            x             <= '0;
            y             <= '0;
            bar           <= '0;
            run           <= '0;
            idx           <= '0;
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TDATA  <= TBITS'(pix(pattern_sel, solid_rgb, 8'd0, 3'd0, 32'd0));
            M_AXIS_TKEEP  <= '1;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TUSER  <= 1'b1;
            busy          <= 1'b1;
            state         <= ACTIVE;
          end else begin
            state <= IDLE;
          end
        end
        ACTIVE: begin
          if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            if (last_x && last_y) begin
              M_AXIS_TVALID <= 1'b0;
              M_AXIS_TDATA  <= '0;
              M_AXIS_TKEEP  <= '0;
              M_AXIS_TLAST  <= 1'b0;
              M_AXIS_TUSER  <= 1'b0;
              busy          <= 1'b0;
              frame_done    <= 1'b1;
              state         <= FEND;
            end else begin
              x            <= nx;
              y            <= ny;
              bar          <= nbar;
              run          <= nrun;
              idx          <= nidx;
              M_AXIS_TDATA <= TBITS'(pix(pat, solid, nx_r, nbar, nidx));
              M_AXIS_TLAST <= (nx == XW'(IMG_W - 1));
              M_AXIS_TUSER <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule
